// File: rtl/ecc_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : ecc_arb_if
// Purpose  : Bundle of request/grant/completion signals between the two ECC
//            command masters, the arbiter and the ECC core control unit.
// Ports    : (interface signals)
//   req0/req1    request level per port           op0/op1   ECC op per port
//   gnt0/gnt1    port owns the core               done0/1   completion pulse
//   err0/err1    completion status (1 = aborted)  abort     abort current op
//   busy         arbiter not idle                 ecc_rdy   core idle/ready
//   ecc_en       core start strobe                ecc_op    core op code
//   ecc_clr      core clear strobe
// Modports : slave  - seen from the arbiter (takes requests, drives the core)
//            master - seen from the requesters / core model
// Revision : 1.0 - initial release
// ============================================================================
interface ecc_arb_if;
    logic       req0;
    logic [1:0] op0;
    logic       gnt0;
    logic       done0;
    logic       err0;
    logic       req1;
    logic [1:0] op1;
    logic       gnt1;
    logic       done1;
    logic       err1;
    logic       abort;
    logic       busy;
    logic       ecc_rdy;
    logic       ecc_en;
    logic [1:0] ecc_op;
    logic       ecc_clr;

    modport slave (
        input  req0, op0, req1, op1, abort, ecc_rdy,
        output gnt0, done0, err0, gnt1, done1, err1, busy,
               ecc_en, ecc_op, ecc_clr
    );

    modport master (
        output req0, op0, req1, op1, abort, ecc_rdy,
        input  gnt0, done0, err0, gnt1, done1, err1, busy,
               ecc_en, ecc_op, ecc_clr
    );
endinterface
`default_nettype wire

// File: rtl/ecc_arb.sv
`default_nettype none
// ============================================================================
// Module   : ecc_arb
// Purpose  : Two-port round-robin command arbiter and sequencer for the ECC
//            core. Grants the core to one master, issues a one-cycle start,
//            tracks the core through busy/idle, reports completion per port
//            and recovers from watchdog timeout or abort via ecc_clr.
// Ports    :
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset
//   bus    ecc_arb_if.slave - request/grant/done/err per port, abort, busy,
//          and the core handshake (ecc_rdy in; ecc_en/ecc_op/ecc_clr out)
// Parameters:
//   TO_W       width of the watchdog counter
//   TO_CYCLES  cycles from ISSUE to completion before forced abort (>= 2)
// Revision : 1.0 - initial release
// ============================================================================
module ecc_arb #(
    parameter int TO_W      = 16,
    parameter int TO_CYCLES = 16'hFFFF
) (
    input  logic      clk,
    input  logic      rst_n,
    ecc_arb_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_BUSY  = 3'd2,
        ST_WAIT_DONE  = 3'd3,
        ST_ABORT      = 3'd4,
        ST_ABORT_WAIT = 3'd5,
        ST_DONE       = 3'd6
    } state_t;

    // Counter value at which the watchdog fires. The counter is 0 during
    // ISSUE, so reaching this value in a WAIT state means TO_CYCLES cycles
    // have elapsed from ISSUE by the time ABORT is entered.
    localparam logic [TO_W-1:0] c_to_last = TO_W'(TO_CYCLES - 1);

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    state_t          state_q, state_d;
    logic            ptr_q,   ptr_d;     // 0: port 0 favoured on a tie
    logic            owner_q, owner_d;   // port currently granted
    logic [1:0]      op_q,    op_d;      // latched op of the owner
    logic [TO_W-1:0] cnt_q,   cnt_d;     // watchdog counter
    logic            err_q,   err_d;     // completion status pending for DONE

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    logic            busy_q,    busy_d;
    logic            gnt0_q,    gnt0_d;
    logic            gnt1_q,    gnt1_d;
    logic            done0_q,   done0_d;
    logic            done1_q,   done1_d;
    logic            err0_q,    err0_d;
    logic            err1_q,    err1_d;
    logic            ecc_en_q,  ecc_en_d;
    logic [1:0]      ecc_op_q,  ecc_op_d;
    logic            ecc_clr_q, ecc_clr_d;

    logic            w_cnt_hit;
    logic [TO_W-1:0] w_cnt_inc;
    logic            w_pick1;

    // Counter saturates at the compare value instead of wrapping.
    assign w_cnt_hit = (cnt_q == c_to_last);
    assign w_cnt_inc = w_cnt_hit ? cnt_q : cnt_q + TO_W'(1);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        // Port 1 wins when it is the only requester, or on a tie when the
        // pointer favours it.
        w_pick1 = bus.req1 && (!bus.req0 || ptr_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.ecc_rdy && (bus.req0 || bus.req1)) begin
                    owner_d = w_pick1;
                    op_d    = w_pick1 ? bus.op1 : bus.op0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                cnt_d   = w_cnt_inc;
                state_d = ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
                cnt_d = w_cnt_inc;
                if (!bus.ecc_rdy) begin
                    state_d = ST_WAIT_DONE;
                end else if (w_cnt_hit || bus.abort) begin
                    state_d = ST_ABORT;
                end
            end

            ST_WAIT_DONE: begin
                cnt_d = w_cnt_inc;
                // Completion beats timeout and abort in the same cycle.
                if (bus.ecc_rdy) begin
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (w_cnt_hit || bus.abort) begin
                    state_d = ST_ABORT;
                end
            end

            ST_ABORT: begin
                err_d   = 1'b1;
                state_d = ST_ABORT_WAIT;
            end

            // The core returns to ready after its clear; no watchdog and no
            // abort here, since ecc_clr has already been issued.
            ST_ABORT_WAIT: begin
                if (bus.ecc_rdy) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                ptr_d   = ~owner_q;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode from the next state, so every output is a flop and has
    // no combinational path from any input.
    // ------------------------------------------------------------------------
    always_comb begin
        busy_d    = (state_d != ST_IDLE);
        gnt0_d    = busy_d && !owner_d;
        gnt1_d    = busy_d &&  owner_d;
        ecc_en_d  = (state_d == ST_ISSUE);
        ecc_op_d  = ecc_en_d ? op_d : 2'b00;
        ecc_clr_d = (state_d == ST_ABORT);
        done0_d   = (state_d == ST_DONE) && !owner_d;
        done1_d   = (state_d == ST_DONE) &&  owner_d;
        err0_d    = done0_d && err_d;
        err1_d    = done1_d && err_d;
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            op_q      <= 2'b00;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            ecc_en_q  <= 1'b0;
            ecc_op_q  <= 2'b00;
            ecc_clr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            ecc_en_q  <= ecc_en_d;
            ecc_op_q  <= ecc_op_d;
            ecc_clr_q <= ecc_clr_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.done0   = done0_q;
    assign bus.done1   = done1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;
    assign bus.ecc_en  = ecc_en_q;
    assign bus.ecc_op  = ecc_op_q;
    assign bus.ecc_clr = ecc_clr_q;

endmodule
`default_nettype wire

// File: doc/ecc_arb.md
Name: ecc_arb

Overview:
- Two-port command arbiter and sequencer in front of the ECC core control unit.
- Accepts ECC operation requests from two masters (port 0: SPI command decoder, port 1: internal key-management sequencer) and grants the single ECC core round-robin.
- Issues the one-cycle ecc_en/ecc_op start, tracks core busy/idle via ecc_rdy and reports completion per port.
- Enforces a watchdog timeout and supports abort, both recovered through the core's ecc_clr.

Parameters:
- TO_W, 16: width of the watchdog counter.
- TO_CYCLES, 16'hFFFF: maximum cycles from start (ISSUE) to completion before forced abort; must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- req0  input  1  port-0 request level, sampled only in IDLE
- op0  input  2  port-0 ECC op (00 ECDH_SK, 01 ECDSA_SIGN, 10 ECDSA_VERI, 11 ECDH_PK)
- gnt0  output  1  port 0 owns the core
- done0  output  1  one-cycle completion pulse to port 0
- err0  output  1  valid with done0; 1 = timeout or abort
- req1, op1, gnt1, done1, err1  same as port 0, for port 1
- abort  input  1  abort the current granted operation
- busy  output  1  high in any state other than IDLE
- ecc_rdy  input  1  core idle/ready
- ecc_en  output  1  core start strobe
- ecc_op  output  2  core op, valid while ecc_en = 1
- ecc_clr  output  1  core clear strobe

Behaviour:
- All outputs decode from registered state only; no combinational input-to-output path.
- Reset when rst_n = 0 at a clk edge, including mid-operation:
  - state = IDLE, round-robin pointer favours port 0.
  - All outputs 0; ecc_op = 00; counter = 0.
  - The core shares rst_n; no ecc_clr is issued on reset.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, ABORT, ABORT_WAIT, DONE.
- IDLE:
  - Grant only if ecc_rdy = 1 and at least one req is high.
  - If one port requests, grant it. If both request, grant the port the pointer favours.
  - Latch the granted id and its op; go to ISSUE.
  - A req dropped before being sampled in IDLE is never served.
- ISSUE: exactly one cycle.
  - ecc_en = 1, ecc_op = latched op.
  - Counter cleared to 0; go to WAIT_BUSY.
- gnt of the owning port is 1 from ISSUE through DONE inclusive, and in ABORT/ABORT_WAIT.
- WAIT_BUSY: counter increments each cycle.
  - ecc_rdy = 0 → WAIT_DONE.
  - Else counter == TO_CYCLES-1 → ABORT.
  - Else abort = 1 → ABORT.
- WAIT_DONE: counter increments each cycle.
  - ecc_rdy = 1 → DONE with err pending = 0.
  - Completion has priority over both timeout and abort in the same cycle.
  - Else counter == TO_CYCLES-1 or abort = 1 → ABORT.
- ABORT: exactly one cycle; ecc_clr = 1, err pending = 1; go to ABORT_WAIT.
- ABORT_WAIT: wait for ecc_rdy = 1 (core passes through its clear state), then → DONE.
  - No second timeout applies in this state.
  - abort is ignored.
- DONE: one cycle.
  - done of the owner = 1, err of the owner = err pending.
  - Pointer now favours the other port.
  - Go to IDLE.
- A requester must drop req on the edge after done. A req still high in the following IDLE is a new request.
- Nominal latency:
  - req sampled at cycle n → ISSUE at n+1 → WAIT_BUSY at n+2.
  - done0/done1 asserts the cycle after ecc_rdy is seen high in WAIT_DONE.
- Counter width: TO_W bits, never wraps; it saturates at the compare.
- abort while IDLE or DONE has no effect.

Test Plan:
1. req0 = 1, op0 = 01; core model drops ecc_rdy 1 cycle after ecc_en and restores it after 100 cycles → exactly one ecc_en cycle with ecc_op = 01; gnt0 high throughout; done0 = 1 with err0 = 0; gnt1/done1 stay 0.
2. After reset, req0 and req1 rise together with op0 = 00, op1 = 11 → port 0 served first (ecc_op = 00), then port 1 (ecc_op = 11). Both requesting again → port 0 served next.
3. TO_CYCLES = 20, core never restores ecc_rdy → ecc_clr one-cycle pulse 20 cycles after ISSUE. Model restores ecc_rdy 2 cycles later → done = 1, err = 1; no second ecc_en.
4. Core never drops ecc_rdy after ecc_en (stuck), TO_CYCLES = 20 → abort from WAIT_BUSY with ecc_clr; done/err = 1; next request is granted normally.
5. abort = 1 at cycle 50 of a 100-cycle op → ecc_clr next cycle; done = 1, err = 1. Repeat with abort in the same cycle ecc_rdy returns → done = 1, err = 0, no ecc_clr.
6. rst_n = 0 for one edge mid-WAIT_DONE → next cycle: busy, gnt*, ecc_en, ecc_clr all 0 and state IDLE. A subsequent req1 = 1 with req0 = 0 is granted to port 1.
